rst_tick_sequencer: RTL and testbench

//  Synthesizable successor to the bench-level reset/clock-tick generation tasks.
//  - Sequences NUM_RST reset outputs through staged deassertion with a programmable gap.
//  - Then runs NUM_TICK independent programmable tick generators.
//  - A run timer ends the session with done_o.
//  - Sits at the top of the block-level environment; drives reset and time-base for downstream IP.

---
 rtl/rst_tick_pkg.sv | 23 ++
 rtl/tick_divider.sv | 64 ++++++
 rtl/rst_tick_sequencer.sv | 178 +++++++++++++++++
 tb/tb_rst_tick_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rst_tick_pkg.sv
// Shared types and constants for the reset/tick sequencer.
package rst_tick_pkg;

    localparam int PKG_DLY_W = 8;
    localparam int PKG_DIV_W = 8;
    localparam int PKG_TMO_W = 16;
    localparam int PKG_CNT_W = 16;

    localparam int MIN_DLY = 1;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RELEASE,
        RUN,
        DONE
    } state_e;

    typedef logic [PKG_DLY_W-1:0] dly_t;
    typedef logic [PKG_DIV_W-1:0] div_t;
    typedef logic [PKG_TMO_W-1:0] tmo_t;

endpackage

// File: rtl/tick_divider.sv
// One programmable tick channel: pulses every div+1 enabled cycles.
// With TICK_CNT_EN defined it also keeps a saturating count of issued ticks.
module tick_divider #(
    parameter int DIV_W = 8
`ifdef TICK_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
`ifdef TICK_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic [DIV_W-1:0] r_phase;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = en && (r_phase == div);
    assign tick   = r_tick;

    // Phase is held at zero while disabled so the first tick lands div+1
    // cycles after enable rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_tick  <= 1'b0;
        end else if (!en || clr) begin
            // NOTE: sequential state always uses non-blocking assignment.
            r_phase <= '0;
            r_tick  <= 1'b0;
        end else if (w_wrap) begin
            r_phase <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_phase <= r_phase + 1'b1;
            r_tick  <= 1'b0;
        end
    end

`ifdef TICK_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    assign cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_wrap && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/rst_tick_sequencer.sv
// Staged reset release followed by a timed run of programmable tick channels.
// Optional per-channel tick counters are built when TICK_CNT_EN is defined.
module rst_tick_sequencer
    import rst_tick_pkg::*;
#(
    parameter int NUM_RST  = 4,
    parameter int NUM_TICK = 2,
    parameter int DLY_W    = PKG_DLY_W,
    parameter int DIV_W    = PKG_DIV_W,
    parameter int TMO_W    = PKG_TMO_W
`ifdef TICK_CNT_EN
    ,
    parameter int CNT_W    = PKG_CNT_W
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [DLY_W-1:0]          dly_i,
    input  logic [NUM_TICK*DIV_W-1:0] div_i,
    input  logic [TMO_W-1:0]          timeout_i,
    output logic [NUM_RST-1:0]        rst_n_o,
    output logic [NUM_TICK-1:0]       tick_o,
    output logic                      busy_o,
    output logic                      done_o
`ifdef TICK_CNT_EN
    ,
    output logic [NUM_TICK*CNT_W-1:0] tick_cnt_o
`endif
);

    localparam int STG_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_RST - 1);

    state_e                    r_state,  w_state_nxt;
    logic [DLY_W-1:0]          r_dly;
    logic [NUM_TICK*DIV_W-1:0] r_div;
    logic [TMO_W-1:0]          r_tmo;
    logic [DLY_W-1:0]          r_cnt,    w_cnt_nxt;
    logic [STG_W-1:0]          r_stage,  w_stage_nxt;
    logic [TMO_W-1:0]          r_timer,  w_timer_nxt;
    logic [NUM_RST-1:0]        r_rst_n,  w_rst_n_nxt;
    logic                      r_busy,   r_done;
    logic                      w_capture, w_tick_en, w_clr, w_abort;
    logic                      w_dly_hit, w_tmo_hit;

    assign w_abort   = abort_i && (r_state != IDLE);
    assign w_dly_hit = (r_cnt == (r_dly - 1'b1));
    assign w_tmo_hit = (r_tmo != '0) && ((r_timer + 1'b1) == r_tmo);
    assign w_clr     = w_capture || w_abort;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stage_nxt = r_stage;
        w_timer_nxt = r_timer;
        w_rst_n_nxt = r_rst_n;
        w_capture   = 1'b0;
        w_tick_en   = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                    w_timer_nxt = '0;
                    w_rst_n_nxt = '0;
                end
            end
            HOLD: begin
                if (w_dly_hit) begin
                    w_cnt_nxt      = '0;
                    w_rst_n_nxt[0] = 1'b1;
                    w_stage_nxt    = STG_W'(1);
                    w_state_nxt    = (NUM_RST == 1) ? RUN : RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (w_dly_hit) begin
                    w_cnt_nxt            = '0;
                    w_rst_n_nxt[r_stage] = 1'b1;
                    if (r_stage == LAST_STG) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_stage_nxt = r_stage + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                w_timer_nxt = r_timer + 1'b1;
                if (w_tmo_hit) begin
                    w_state_nxt = DONE;
                end else begin
                    w_tick_en = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Abort overrides start, timeout and any tick in flight.
        if (w_abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
            w_timer_nxt = '0;
            w_rst_n_nxt = '0;
            w_capture   = 1'b0;
            w_tick_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stage <= '0;
            r_timer <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stage <= w_stage_nxt;
            r_timer <= w_timer_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_busy  <= (w_state_nxt == HOLD) || (w_state_nxt == RELEASE) || (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // NOTE: shadow registers are reset too; cheap here and keeps IDLE fully defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
            r_div <= '0;
            r_tmo <= '0;
        end else if (w_capture) begin
            r_dly <= (dly_i < DLY_W'(MIN_DLY)) ? DLY_W'(MIN_DLY) : dly_i;
            r_div <= div_i;
            r_tmo <= timeout_i;
        end
    end

    for (genvar k = 0; k < NUM_TICK; k++) begin : g_tick
        tick_divider #(
            .DIV_W (DIV_W)
`ifdef TICK_CNT_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_div (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (w_tick_en),
            .clr   (w_clr),
            .div   (r_div[k*DIV_W +: DIV_W]),
            .tick  (tick_o[k])
`ifdef TICK_CNT_EN
            ,
            .cnt   (tick_cnt_o[k*CNT_W +: CNT_W])
`endif
        );
    end

    assign rst_n_o = r_rst_n;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_rst_tick_sequencer.sv
// Directed self-checking bench for rst_tick_sequencer (default parameters).
module tb_rst_tick_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [7:0]  dly_i;
    logic [15:0] div_i;
    logic [15:0] timeout_i;
    logic [3:0]  rst_n_o;
    logic [1:0]  tick_o;
    logic        busy_o;
    logic        done_o;
`ifdef TICK_CNT_EN
    logic [31:0] tick_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rst_tick_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .dly_i      (dly_i),
        .div_i      (div_i),
        .timeout_i  (timeout_i),
        .rst_n_o    (rst_n_o),
        .tick_o     (tick_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef TICK_CNT_EN
        ,
        .tick_cnt_o (tick_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observed outputs packed as {rst_n_o, tick_o, busy_o, done_o}.
    function automatic logic [31:0] outs();
        return {24'd0, rst_n_o, tick_o, busy_o, done_o};
    endfunction

    // Expected outputs e cycles after the start sample edge, for effective
    // delay d, dividers v0/v1 and timeout tmo (0 = never done).
    function automatic logic [31:0] exp_vec(int e, int d, int v0, int v1, int tmo);
        logic [3:0] r;
        logic [1:0] t;
        int run0, done_e;
        run0   = 4 * d;
        done_e = (tmo != 0) ? run0 + tmo : 32'h7fff_ffff;
        for (int i = 0; i < 4; i++) r[i] = (e >= d * (i + 1));
        t[0] = (e > run0) && (e < done_e) && (((e - run0) % (v0 + 1)) == 0);
        t[1] = (e > run0) && (e < done_e) && (((e - run0) % (v1 + 1)) == 0);
        return {24'd0, r, t, (e < done_e), (e >= done_e)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulses start with the given settings, then scrambles the inputs to
    // prove they were captured. Returns at the negedge after the sample edge.
    task automatic start_session(input logic [7:0] d, input logic [7:0] v0,
                                 input logic [7:0] v1, input logic [15:0] tmo);
        dly_i     = d;
        div_i     = {v1, v0};
        timeout_i = tmo;
        start_i   = 1'b1;
        cyc();
        start_i   = 1'b0;
        dly_i     = 8'hff;
        div_i     = 16'hffff;
        timeout_i = 16'h0001;
    endtask

    initial begin
        rst_n     = 1'b1;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        dly_i     = '0;
        div_i     = '0;
        timeout_i = '0;
        #1 rst_n  = 1'b0;
        #2;
        check("reset_state", outs(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("idle_after_reset", outs(), 32'd0);

        // Staged release with dly=5, then ticks div=1/3 until timeout 20.
        start_session(8'd5, 8'd1, 8'd3, 16'd20);
        check("seq_e0", outs(), exp_vec(0, 5, 1, 3, 20));
        for (int e = 1; e <= 45; e++) begin
            cyc();
            check($sformatf("seq_e%0d", e), outs(), exp_vec(e, 5, 1, 3, 20));
        end

        // Restart from DONE; dly=0 behaves as 1, div=0 ticks every cycle.
        start_session(8'd0, 8'd0, 8'd0, 16'd3);
        check("dly0_e0", outs(), exp_vec(0, 1, 0, 0, 3));
        for (int e = 1; e <= 9; e++) begin
            cyc();
            check($sformatf("dly0_e%0d", e), outs(), exp_vec(e, 1, 0, 0, 3));
        end

        // timeout=0 runs indefinitely; a start while busy is ignored.
        start_session(8'd1, 8'd0, 8'd0, 16'd0);
        for (int e = 1; e <= 1000; e++) begin
            if (e == 3) begin
                dly_i   = 8'd7;
                div_i   = 16'h0505;
                start_i = 1'b1;
            end
            cyc();
            start_i = 1'b0;
            check($sformatf("notmo_e%0d", e), outs(), exp_vec(e, 1, 0, 0, 0));
        end

        // Async reset between clock edges while in RUN.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_immediate", outs(), 32'd0);
        #1 rst_n = 1'b1;
        cyc();
        check("async_rst_no_resume", outs(), 32'd0);

        // Abort after bit 1 is released.
        start_session(8'd2, 8'd0, 8'd0, 16'd50);
        for (int e = 1; e <= 4; e++) begin
            cyc();
            check($sformatf("abort_rel_e%0d", e), outs(), exp_vec(e, 2, 0, 0, 50));
        end
        abort_i = 1'b1;
        cyc();
        check("abort_release", outs(), 32'd0);
        cyc();
        check("abort_in_idle", outs(), 32'd0);
        abort_i = 1'b0;

        // Clean restart, then abort and start together in DONE.
        start_session(8'd1, 8'd0, 8'd1, 16'd4);
        for (int e = 1; e <= 9; e++) begin
            cyc();
            check($sformatf("restart_e%0d", e), outs(), exp_vec(e, 1, 0, 1, 4));
        end
        abort_i = 1'b1;
        start_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_beats_start", outs(), 32'd0);

        // Abort on the same cycle the timeout would fire.
        start_session(8'd1, 8'd0, 8'd0, 16'd2);
        for (int e = 1; e <= 5; e++) begin
            cyc();
            check($sformatf("abort_tmo_e%0d", e), outs(), exp_vec(e, 1, 0, 0, 2));
        end
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        check("abort_beats_timeout", outs(), 32'd0);

`ifdef TICK_CNT_EN
        // div=2, timeout=30: ticks at run+3..run+27 -> 9; div=0 -> 29.
        start_session(8'd1, 8'd2, 8'd0, 16'd30);
        repeat (40) cyc();
        check("tick_cnt_done", tick_cnt, {16'd29, 16'd9});
        cyc();
        check("tick_cnt_held", tick_cnt, {16'd29, 16'd9});
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        check("tick_cnt_abort_clr", tick_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
